// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state enum, default sizes and grant rule for mem_arbiter
package mem_arb_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    // Data wins by default; fetch wins once it has lost two grants in a row.
    function automatic arb_state_e pick_owner(input logic if_req, input logic d_req,
                                              input logic [1:0] starve);
        arb_state_e owner;
        owner = IDLE;
        if (if_req && (starve >= 2'd2 || !d_req))
            owner = BUSY_I;
        else if (d_req)
            owner = BUSY_D;
        return owner;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory signals of mem_arbiter
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req;
    logic [DATA_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              d_req;
    logic              d_we;
    logic [DATA_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stall_if;
    logic              stall_mem;
    logic              err;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, err
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, err
    );

endinterface

// File: rtl/mem_arb_timeout.sv
// rtl/mem_arb_timeout.sv - busy-cycle watchdog, flags the cycle a transaction must be aborted
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    input  logic ready,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    // Fires on the TIMEOUT_CYC-th consecutive busy cycle without ready.
    assign expired = busy & ~ready & (cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (start)
            cnt <= '0;
        else if (busy && !ready)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one single-port memory; MEM_ARB_TIMEOUT_EN adds abort on stuck memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);
    arb_state_e        state_q, state_d, pick;
    logic [1:0]        starve_q;
    logic              we_q;
    logic [DATA_W-1:0] addr_q, wdata_q, if_rdata_q, d_rdata_q;
    logic              if_ack_q, d_ack_q, err_q;
    logic              busy, done, abort, arb, load;

    assign busy = (state_q != IDLE);
    assign done = busy & bus.mem_ready;
    assign pick = pick_owner(bus.if_req, bus.d_req, starve_q);
    // Arbitrate from IDLE or in the completion cycle, so back-to-back grants skip IDLE.
    assign arb  = ~busy | done;
    assign load = arb & (pick != IDLE);

    always_comb begin
        state_d = state_q;
        if (abort)
            state_d = IDLE;
        else if (arb)
            state_d = pick;
    end

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .start   (load),
        .busy    (busy),
        .ready   (bus.mem_ready),
        .expired (abort)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign abort          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            starve_q   <= 2'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            if_ack_q <= (state_q == BUSY_I) & (done | abort);
            d_ack_q  <= (state_q == BUSY_D) & (done | abort);
            if (state_q == BUSY_I && (done || abort))
                if_rdata_q <= abort ? '0 : bus.mem_rdata;
            if (state_q == BUSY_D && (done || abort))
                d_rdata_q <= abort ? '0 : bus.mem_rdata;
            if (abort)
                err_q <= 1'b1;
            if (load) begin
                addr_q  <= (pick == BUSY_D) ? bus.d_addr : bus.if_addr;
                we_q    <= (pick == BUSY_D) & bus.d_we;
                wdata_q <= (pick == BUSY_D) ? bus.d_wdata : '0;
                if (pick == BUSY_I || !bus.if_req)
                    starve_q <= 2'd0;
                else if (starve_q != 2'd3)
                    starve_q <= starve_q + 2'd1;
            end
        end
    end

    assign bus.mem_req   = busy;
    assign bus.mem_we    = busy & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.err       = err_q;
    assign bus.stall_if  = bus.if_req & ~if_ack_q;
    assign bus.stall_mem = bus.d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction model
module tb_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int TO    = 4;
`else
    localparam bit TO_EN = 1'b0;
    localparam int TO    = 255;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_W(32)) bus ();

    mem_arbiter #(.DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Model: owner 0 = none, 1 = fetch, 2 = data.
    int          m_owner = 0, m_lost = 0, m_wait = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_d_rdata = 0;
    logic        m_we = 0, m_if_ack = 0, m_d_ack = 0, m_err = 0;

    always @(posedge clk or negedge rst) begin
        int          own, lost, wt;
        logic [31:0] ir, dr;
        logic        ia, da, er, fin, abt;
        if (!rst) begin
            m_owner <= 0; m_lost <= 0; m_wait <= 0;
            m_addr <= 0; m_wdata <= 0; m_we <= 0;
            m_if_rdata <= 0; m_d_rdata <= 0;
            m_if_ack <= 0; m_d_ack <= 0; m_err <= 0;
        end else begin
            own = m_owner; lost = m_lost; wt = m_wait;
            ir = m_if_rdata; dr = m_d_rdata; er = m_err;
            ia = 0; da = 0; abt = 0;
            fin = (own != 0) && bus.mem_ready;
            if (own != 0 && !bus.mem_ready) begin
                wt = wt + 1;
                abt = TO_EN && (wt == TO);
            end
            if (fin || abt) begin
                if (own == 1) begin ia = 1; ir = fin ? bus.mem_rdata : 32'h0; end
                else          begin da = 1; dr = fin ? bus.mem_rdata : 32'h0; end
            end
            if (abt) begin
                own = 0;
                er  = 1;
            end else if (own == 0 || fin) begin
                if (bus.if_req && (lost >= 2 || !bus.d_req)) begin
                    own = 1; lost = 0; wt = 0;
                    m_addr <= bus.if_addr; m_we <= 0;
                end else if (bus.d_req) begin
                    own = 2; wt = 0;
                    lost = bus.if_req ? lost + 1 : 0;
                    m_addr <= bus.d_addr; m_we <= bus.d_we; m_wdata <= bus.d_wdata;
                end else begin
                    own = 0;
                end
            end
            m_owner <= own; m_lost <= lost; m_wait <= wt;
            m_if_rdata <= ir; m_d_rdata <= dr;
            m_if_ack <= ia; m_d_ack <= da; m_err <= er;
        end
    end

    always @(negedge clk) begin
        chk("mem_req", {31'b0, bus.mem_req}, {31'b0, m_owner != 0});
        chk("mem_we", {31'b0, bus.mem_we}, {31'b0, (m_owner == 2) && m_we});
        if (m_owner != 0) chk("mem_addr", bus.mem_addr, m_addr);
        if (m_owner == 2) chk("mem_wdata", bus.mem_wdata, m_wdata);
        chk("if_ack", {31'b0, bus.if_ack}, {31'b0, m_if_ack});
        chk("d_ack", {31'b0, bus.d_ack}, {31'b0, m_d_ack});
        chk("if_rdata", bus.if_rdata, m_if_rdata);
        chk("d_rdata", bus.d_rdata, m_d_rdata);
        chk("err", {31'b0, bus.err}, {31'b0, m_err});
        chk("stall_if", {31'b0, bus.stall_if}, {31'b0, bus.if_req & ~m_if_ack});
        chk("stall_mem", {31'b0, bus.stall_mem}, {31'b0, bus.d_req & ~m_d_ack});
    end

    task automatic idle_inputs();
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
    endtask

    logic [31:0] grant_exp [6];

    initial begin
        idle_inputs();
        #1 rst = 1'b0;
        tick(); tick();
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_err", {31'b0, bus.err}, 32'h0);
        rst = 1'b1;
        tick();

        // Fetch only, memory ready on the third busy cycle.
        bus.if_req = 1; bus.if_addr = 32'h40; bus.mem_rdata = 32'hDEAD0040;
        tick();
        chk("s1_mem_req", {31'b0, bus.mem_req}, 32'h1);
        chk("s1_mem_addr", bus.mem_addr, 32'h40);
        chk("s1_mem_we", {31'b0, bus.mem_we}, 32'h0);
        bus.if_req = 0;
        tick(); tick();
        chk("s1_no_early_ack", {31'b0, bus.if_ack}, 32'h0);
        bus.mem_ready = 1;
        tick();
        chk("s1_if_ack", {31'b0, bus.if_ack}, 32'h1);
        chk("s1_if_rdata", bus.if_rdata, 32'hDEAD0040);
        bus.mem_ready = 0;
        tick();
        chk("s1_ack_single", {31'b0, bus.if_ack}, 32'h0);
        chk("s1_idle", {31'b0, bus.mem_req}, 32'h0);

        // Simultaneous requests: data write first, then fetch with no idle gap.
        bus.if_req = 1; bus.if_addr = 32'h80;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hA5A5A5A5;
        bus.mem_rdata = 32'h11112222;
        tick();
        chk("s2_d_addr", bus.mem_addr, 32'h100);
        chk("s2_d_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        chk("s2_d_we", {31'b0, bus.mem_we}, 32'h1);
        bus.d_req = 0; bus.mem_ready = 1;
        tick();
        chk("s2_d_ack", {31'b0, bus.d_ack}, 32'h1);
        chk("s2_d_rdata", bus.d_rdata, 32'h11112222);
        chk("s2_no_gap", {31'b0, bus.mem_req}, 32'h1);
        chk("s2_i_addr", bus.mem_addr, 32'h80);
        chk("s2_i_we", {31'b0, bus.mem_we}, 32'h0);
        bus.if_req = 0; bus.mem_rdata = 32'h33334444;
        tick();
        chk("s2_if_ack", {31'b0, bus.if_ack}, 32'h1);
        chk("s2_if_rdata", bus.if_rdata, 32'h33334444);
        bus.mem_ready = 0;
        tick();

        // Both held high: fairness gives D, D, I, D, D, I.
        grant_exp[0] = 32'h300; grant_exp[1] = 32'h300; grant_exp[2] = 32'h200;
        grant_exp[3] = 32'h300; grant_exp[4] = 32'h300; grant_exp[5] = 32'h200;
        bus.if_req = 1; bus.if_addr = 32'h200;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
        bus.mem_ready = 1; bus.mem_rdata = 32'h5555AAAA;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("s3_grant%0d", k), bus.mem_addr, grant_exp[k]);
        end
        bus.if_req = 0; bus.d_req = 0;
        tick();
        bus.mem_ready = 0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        bus.if_req = 1; bus.if_addr = 32'h600;
        tick();
        chk("s5_mem_req", {31'b0, bus.mem_req}, 32'h1);
        bus.if_req = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("s5_wait", {31'b0, bus.if_ack}, 32'h0);
        end
        tick();
        chk("s5_abort_ack", {31'b0, bus.if_ack}, 32'h1);
        chk("s5_abort_rdata", bus.if_rdata, 32'h0);
        chk("s5_err", {31'b0, bus.err}, 32'h1);
        chk("s5_mem_req_drop", {31'b0, bus.mem_req}, 32'h0);
        tick(); tick();
        chk("s5_err_sticky", {31'b0, bus.err}, 32'h1);
        rst = 0;
        tick();
        rst = 1;
        tick();
        chk("s5_err_cleared", {31'b0, bus.err}, 32'h0);
`else
        bus.if_req = 1; bus.if_addr = 32'h600;
        tick();
        bus.if_req = 0;
        for (int k = 0; k < 12; k++) tick();
        chk("s5_still_waiting", {31'b0, bus.mem_req}, 32'h1);
        chk("s5_no_ack", {31'b0, bus.if_ack}, 32'h0);
        chk("s5_no_err", {31'b0, bus.err}, 32'h0);
        bus.mem_ready = 1; bus.mem_rdata = 32'h0BADF00D;
        tick();
        chk("s5_late_ack", {31'b0, bus.if_ack}, 32'h1);
        chk("s5_late_rdata", bus.if_rdata, 32'h0BADF00D);
        bus.mem_ready = 0;
        tick();
`endif

        // Reset in the middle of a data transaction.
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h500; bus.d_wdata = 32'h12345678;
        tick();
        chk("s4_busy", {31'b0, bus.mem_req}, 32'h1);
        bus.d_req = 0;
        #2 rst = 0;
        #1;
        chk("s4_mem_req_async", {31'b0, bus.mem_req}, 32'h0);
        chk("s4_mem_we_async", {31'b0, bus.mem_we}, 32'h0);
        bus.mem_ready = 1;
        tick();
        chk("s4_no_ack", {31'b0, bus.d_ack}, 32'h0);
        rst = 1;
        tick();
        chk("s4_idle", {31'b0, bus.mem_req}, 32'h0);
        chk("s4_no_ack_after", {31'b0, bus.d_ack}, 32'h0);

        for (int c = 0; c < 2000; c++) begin
            bus.if_req    = ($urandom_range(0, 9) < 6);
            bus.if_addr   = $urandom;
            bus.d_req     = ($urandom_range(0, 9) < 5);
            bus.d_we      = $urandom_range(0, 1) == 1;
            bus.d_addr    = $urandom;
            bus.d_wdata   = $urandom;
            bus.mem_ready = ($urandom_range(0, 9) < 6);
            bus.mem_rdata = $urandom;
            tick();
        end

        idle_inputs();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the data and address buses.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, meaning the number of busy cycles without mem_ready before an abort (used only under REQ-024).
REQ-003 SHALL have ports as follows; there is one clock, and reset is asynchronous and active-low:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request.
- if_addr  in  DATA_W  fetch address.
- if_rdata  out  DATA_W  fetch read data.
- if_ack  out  1  fetch completion pulse.
- d_req  in  1  data-stage request.
- d_we  in  1  data write enable.
- d_addr  in  DATA_W  data address.
- d_wdata  in  DATA_W  data write value.
- d_rdata  out  DATA_W  data read value.
- d_ack  out  1  data completion pulse.
- mem_req  out  1  request to the single-port memory.
- mem_we  out  1  memory write enable.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completion, valid while mem_req=1.
- stall_if  out  1  freeze the fetch stage.
- stall_mem  out  1  freeze the memory stage and everything older.
- err  out  1  sticky timeout flag.

Function
REQ-004 SHALL implement the FSM states IDLE, BUSY_I and BUSY_D.
REQ-005 In IDLE, d_req=1 SHALL go to BUSY_D; otherwise if_req=1 SHALL go to BUSY_I; otherwise the FSM stays in IDLE.
REQ-006 On entering a BUSY state, the arbiter SHALL latch the owner's address, write enable and write data into request registers.
REQ-007 mem_req SHALL be 1 exactly while in a BUSY state.
REQ-008 mem_we, mem_addr and mem_wdata SHALL be driven from the request registers and held stable until mem_ready.
REQ-009 mem_we SHALL be 0 in BUSY_I.
REQ-010 When mem_ready=1 in a BUSY state, the arbiter SHALL register mem_rdata into the owner's rdata and pulse the owner's ack for exactly one cycle.
REQ-011 On completion (REQ-010), the next owner SHALL be chosen in the same cycle using the priority of REQ-005, without passing through IDLE.
- Fairness exception: if fetch has lost two consecutive grants while if_req=1, fetch SHALL take the next grant.
- A 2-bit starvation counter SHALL track this; it clears on each fetch grant.
REQ-012 Minimum latency SHALL be: request sampled at edge N, mem_req=1 after edge N, ack=1 after edge N+1 when mem_ready=1 in the first busy cycle.
REQ-013 if_rdata and d_rdata SHALL hold their last value until the next completion for that requester.
REQ-014 stall_if SHALL equal if_req & ~if_ack, combinationally.
REQ-015 stall_mem SHALL equal d_req & ~d_ack, combinationally.
REQ-016 If a requester drops its req before ack, the memory transaction SHALL still complete and the ack SHALL still pulse.
REQ-017 A req held high through its own ack SHALL be treated as a new request in the next arbitration.
REQ-018 If if_req and d_req rise in the same cycle, data SHALL win, subject to REQ-011.
REQ-019 A mem_ready seen in IDLE SHALL be ignored.

Reset
REQ-020 rst=0 SHALL asynchronously force:
- state IDLE;
- mem_req, mem_we, if_ack, d_ack and err to 0;
- mem_addr, mem_wdata, if_rdata and d_rdata to 0;
- the starvation counter to 0.
REQ-021 A reset asserted mid-transaction SHALL abandon that transaction and issue no ack.
REQ-022 After reset is released, the first arbitration SHALL happen at the first rising clk edge.
REQ-023 stall_if and stall_mem SHALL follow REQ-014 and REQ-015 during reset.

Configuration
REQ-024 With MEM_ARB_TIMEOUT_EN defined, the timeout feature SHALL operate as follows:
- A counter clears on entry to a BUSY state and increments on each busy cycle with mem_ready=0.
- On reaching TIMEOUT_CYC, the arbiter aborts the transaction: mem_req drops, the owner's ack pulses, and the owner's rdata is 0.
- err sets and stays set until reset.
REQ-025 Without MEM_ARB_TIMEOUT_EN, no counter SHALL be built, err SHALL be tied to 0, and a transaction SHALL wait indefinitely.

Structure
REQ-026 The state enum (IDLE, BUSY_I, BUSY_D) and the default constants for DATA_W and TIMEOUT_CYC SHALL live in the shared package mem_arb_pkg.
REQ-027 The timeout counter SHALL be the single sub-module mem_arb_timeout, instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Only if_req=1, addr 0x40, mem_ready after 3 cycles -> if_ack pulses once, if_rdata=mem_rdata, mem_we=0 throughout.
- if_req and d_req rise together, d_we=1, addr 0x100, data 0xA5A5A5A5 -> data served first with mem_wdata=0xA5A5A5A5, then fetch, with no idle cycle between.
- d_req held high continuously with if_req=1 -> grant order is D, D, I, D, D, I.
- rst=0 pulsed during BUSY_D -> mem_req drops immediately, no d_ack, state IDLE.
- MEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=4, mem_ready stuck at 0 -> ack pulses after 4 busy cycles with rdata 0, err=1 until reset.
